// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the per-SP pipeline back end.
//   - Default bus widths for the writeback stage.
//   - wb_sel result-select codes (WB_SEL_MULT..WB_SEL_MEM).
//   - occ_state_e: occupancy of the writeback skid buffer.
//   - wb_entry_t: one buffered writeback entry {data, rd, wb_en}.
package pipeline_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_SEL_W  = 3;

    localparam logic [WB_SEL_W-1:0] WB_SEL_MULT    = 3'd0;
    localparam logic [WB_SEL_W-1:0] WB_SEL_SHIFT   = 3'd1;
    localparam logic [WB_SEL_W-1:0] WB_SEL_LOGICAL = 3'd2;
    localparam logic [WB_SEL_W-1:0] WB_SEL_ADD     = 3'd3;
    localparam logic [WB_SEL_W-1:0] WB_SEL_COMPARE = 3'd4;
    localparam logic [WB_SEL_W-1:0] WB_SEL_MEM     = 3'd5;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } occ_state_e;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] rd;
        logic                 wb_en;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: execute-side handshake plus register-file write port of the
// writeback stage.
//   master modport: the environment (execute stage + register file) side.
//   slave  modport: the writeback stage itself.
// Signals: valid_e/ready_e handshake, six result buses, wb_sel_e, wb_en_e, rd_e,
// rf_ready, rf_we, rf_waddr, rf_wdata, retire.
// With WB_BYPASS_EN defined it also carries fwd_valid, fwd_addr, fwd_data.
interface writeback_stage_if #(
    parameter int unsigned R_DATA_WIDTH   = pipeline_pkg::WB_DATA_W,
    parameter int unsigned REG_ADDR_WIDTH = pipeline_pkg::WB_ADDR_W,
    parameter int unsigned SEL_WIDTH      = pipeline_pkg::WB_SEL_W
);
    logic                      valid_e;
    logic                      ready_e;
    logic [R_DATA_WIDTH-1:0]   mult_e;
    logic [R_DATA_WIDTH-1:0]   shift_e;
    logic [R_DATA_WIDTH-1:0]   logical_e;
    logic [R_DATA_WIDTH-1:0]   add_e;
    logic [R_DATA_WIDTH-1:0]   compare_e;
    logic [R_DATA_WIDTH-1:0]   mem_e;
    logic [SEL_WIDTH-1:0]      wb_sel_e;
    logic                      wb_en_e;
    logic [REG_ADDR_WIDTH-1:0] rd_e;
    logic                      rf_ready;
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr;
    logic [R_DATA_WIDTH-1:0]   rf_wdata;
    logic                      retire;
`ifdef WB_BYPASS_EN
    logic                      fwd_valid;
    logic [REG_ADDR_WIDTH-1:0] fwd_addr;
    logic [R_DATA_WIDTH-1:0]   fwd_data;
`endif

    modport master (
        output valid_e, mult_e, shift_e, logical_e, add_e, compare_e, mem_e,
        output wb_sel_e, wb_en_e, rd_e, rf_ready,
`ifdef WB_BYPASS_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        input  ready_e, rf_we, rf_waddr, rf_wdata, retire
    );

    modport slave (
        input  valid_e, mult_e, shift_e, logical_e, add_e, compare_e, mem_e,
        input  wb_sel_e, wb_en_e, rd_e, rf_ready,
`ifdef WB_BYPASS_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        output ready_e, rf_we, rf_waddr, rf_wdata, retire
    );

endinterface

// File: rtl/generic_mux.sv
// generic_mux: N-input one-of-N selector.
//   in  : NUM_INPUTS packed words of WIDTH bits.
//   sel : index of the word to pass; out-of-range indices give zero.
//   out : selected word.
module generic_mux #(
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned WIDTH      = 32,
    localparam int unsigned SelW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0] in,
    input  logic [SelW-1:0]                  sel,
    output logic [WIDTH-1:0]                 out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            if (sel == SelW'(i)) begin
                out = in[i];
            end
        end
    end

endmodule

// File: rtl/wb_skid_buffer.sv
// wb_skid_buffer: 2-entry FIFO with EMPTY/ONE/TWO occupancy FSM, generic in width.
//   push_valid/push_ready : input handshake; push_ready depends only on state.
//   push_data             : entry to enqueue.
//   pop_ready             : consumer takes the head this cycle if head_valid.
//   head_*/tail_*         : registered oldest/youngest entries and their valid flags.
module wb_skid_buffer
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             tail_valid,
    output logic [WIDTH-1:0] tail_data
);

    occ_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    assign push_ready = (state_q != StTwo);
    assign head_valid = (state_q != StEmpty);
    assign tail_valid = (state_q == StTwo);
    assign head_data  = head_q;
    assign tail_data  = tail_q;

    assign push = push_valid && push_ready;
    assign pop  = head_valid && pop_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    // Head leaves while the new entry arrives: it becomes head directly.
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = StTwo;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: captures execute/load results, resolves the destination value at
// input, buffers it in a 2-entry skid buffer and drives the register-file write port.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : writeback_stage_if.slave (execute handshake, result buses,
//                register-file write port, retire strobe).
// Optional macro WB_BYPASS_EN adds fwd_valid/fwd_addr/fwd_data presenting the youngest
// buffered entry that will write a register.
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned R_DATA_WIDTH   = WB_DATA_W,
    parameter int unsigned REG_ADDR_WIDTH = WB_ADDR_W,
    parameter int unsigned SEL_WIDTH      = WB_SEL_W
) (
    input  logic            clk,
    input  logic            rst_n,
    writeback_stage_if.slave bus
);

    localparam int unsigned EntryW = $bits(wb_entry_t);

    logic [7:0][R_DATA_WIDTH-1:0] mux_in;
    logic [R_DATA_WIDTH-1:0]      sel_data;
    logic [SEL_WIDTH-1:0]         sel;
    logic [REG_ADDR_WIDTH-1:0]    rd_in;
    wb_entry_t                    in_entry;
    wb_entry_t                    head, tail;
    logic                         head_valid, tail_valid;

    always_comb begin
        mux_in                 = '0;   // codes 6 and 7 select zero
        mux_in[WB_SEL_MULT]    = bus.mult_e;
        mux_in[WB_SEL_SHIFT]   = bus.shift_e;
        mux_in[WB_SEL_LOGICAL] = bus.logical_e;
        mux_in[WB_SEL_ADD]     = bus.add_e;
        mux_in[WB_SEL_COMPARE] = bus.compare_e;
        mux_in[WB_SEL_MEM]     = bus.mem_e;
    end

    assign sel   = bus.wb_sel_e;
    assign rd_in = bus.rd_e;

    generic_mux #(
        .NUM_INPUTS(8),
        .WIDTH     (R_DATA_WIDTH)
    ) u_sel_mux (
        .in (mux_in),
        .sel(sel),
        .out(sel_data)
    );

    // Register 0 is hard-wired: such entries still retire but never write.
    always_comb begin
        in_entry       = '0;
        in_entry.data  = sel_data;
        in_entry.rd    = rd_in;
        in_entry.wb_en = bus.wb_en_e && (rd_in != '0);
    end

    wb_skid_buffer #(
        .WIDTH(EntryW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(bus.valid_e),
        .push_ready(bus.ready_e),
        .push_data (in_entry),
        .pop_ready (bus.rf_ready),
        .head_valid(head_valid),
        .head_data (head),
        .tail_valid(tail_valid),
        .tail_data (tail)
    );

    // rf_we/retire are the only terms combinational on rf_ready.
    assign bus.rf_we    = head_valid && head.wb_en && bus.rf_ready;
    assign bus.retire   = head_valid && bus.rf_ready;
    assign bus.rf_waddr = head.rd;
    assign bus.rf_wdata = head.data;

`ifdef WB_BYPASS_EN
    // Youngest writing entry wins so decode sees the newest value for a register.
    always_comb begin
        bus.fwd_valid = 1'b0;
        bus.fwd_addr  = head.rd;
        bus.fwd_data  = head.data;
        if (tail_valid && tail.wb_en) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_addr  = tail.rd;
            bus.fwd_data  = tail.data;
        end else if (head_valid && head.wb_en) begin
            bus.fwd_valid = 1'b1;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ^{tail, tail_valid};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios plus a randomized run checked against a
// queue-based reference model of the writeback stage.
module tb_writeback_stage;
    import pipeline_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: in-order list of buffered entries, at most two.
    wb_entry_t mq[$];

    function automatic logic [31:0] sel_val(input logic [2:0] s);
        case (s)
            3'd0: return bus.mult_e;
            3'd1: return bus.shift_e;
            3'd2: return bus.logical_e;
            3'd3: return bus.add_e;
            3'd4: return bus.compare_e;
            3'd5: return bus.mem_e;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] rd,
                         input logic wb, input logic [31:0] val);
        bus.valid_e   = v;
        bus.wb_sel_e  = s;
        bus.rd_e      = rd;
        bus.wb_en_e   = wb;
        bus.mult_e    = $urandom;
        bus.shift_e   = $urandom;
        bus.logical_e = $urandom;
        bus.add_e     = $urandom;
        bus.compare_e = $urandom;
        bus.mem_e     = $urandom;
        case (s)
            3'd0: bus.mult_e    = val;
            3'd1: bus.shift_e   = val;
            3'd2: bus.logical_e = val;
            3'd3: bus.add_e     = val;
            3'd4: bus.compare_e = val;
            3'd5: bus.mem_e     = val;
            default: ;
        endcase
    endtask

    // Advance one clock, updating the model with this cycle's push/pop.
    task automatic tick();
        bit        push, pop;
        wb_entry_t e;
        push    = bus.valid_e && (mq.size() < 2);
        pop     = (mq.size() > 0) && bus.rf_ready;
        e.data  = sel_val(bus.wb_sel_e);
        e.rd    = bus.rd_e;
        e.wb_en = bus.wb_en_e && (bus.rd_e != 5'd0);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        bus.rf_ready = 1'b1;
        rst_n = 1'b0;
        mq.delete();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.ready_e !== 1'b1) begin n_fail++; $display("FAIL reset_ready_e: got %b want 1", bus.ready_e); end
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        n_checks++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d want 0", bus.rf_waddr); end
        n_checks++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); end
        n_checks++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b want 0", bus.retire); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_push();
        bus.rf_ready = 1'b1;
        drive(1'b1, 3'd3, 5'd7, 1'b1, 32'h5);
        #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_before: got %b want 0", bus.rf_we); end
        tick();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL single_rf_we: got %b want 1", bus.rf_we); end
        n_checks++; if (bus.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL single_rf_waddr: got %0d want 7", bus.rf_waddr); end
        n_checks++; if (bus.rf_wdata !== 32'h5) begin n_fail++; $display("FAIL single_rf_wdata: got %h want 5", bus.rf_wdata); end
        n_checks++; if (bus.retire !== 1'b1) begin n_fail++; $display("FAIL single_retire: got %b want 1", bus.retire); end
        tick();
        #1;
        n_checks++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL single_empty_retire: got %b want 0", bus.retire); end
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_empty_we: got %b want 0", bus.rf_we); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3] = '{32'h10, 32'h20, 32'h30};
        logic [2:0]  sels[3] = '{3'd0, 3'd1, 3'd5};
        logic [4:0]  rds[3]  = '{5'd1, 5'd2, 5'd3};
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, sels[i], rds[i], 1'b1, vals[i]);
            else drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
            #1;
            n_checks++; if (bus.ready_e !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_e[%0d]: got %b want 1", i, bus.ready_e); end
            n_checks++; if (bus.rf_we !== (i > 0)) begin n_fail++; $display("FAIL b2b_rf_we[%0d]: got %b want %b", i, bus.rf_we, i > 0); end
            if (i > 0) begin
                n_checks++; if (bus.rf_wdata !== vals[i-1]) begin n_fail++; $display("FAIL b2b_rf_wdata[%0d]: got %h want %h", i, bus.rf_wdata, vals[i-1]); end
                n_checks++; if (bus.rf_waddr !== rds[i-1]) begin n_fail++; $display("FAIL b2b_rf_waddr[%0d]: got %0d want %0d", i, bus.rf_waddr, rds[i-1]); end
            end
            tick();
        end
    endtask

    task automatic test_stall_fill();
        bus.rf_ready = 1'b0;
        drive(1'b1, 3'd3, 5'd11, 1'b1, 32'hA1);
        #1; tick();
        drive(1'b1, 3'd2, 5'd12, 1'b1, 32'hB2);
        #1;
        n_checks++; if (bus.ready_e !== 1'b1) begin n_fail++; $display("FAIL stall_ready_one: got %b want 1", bus.ready_e); end
        tick();
        drive(1'b1, 3'd4, 5'd13, 1'b1, 32'hC3);
        #1;
        n_checks++; if (bus.ready_e !== 1'b0) begin n_fail++; $display("FAIL stall_ready_two: got %b want 0", bus.ready_e); end
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL stall_rf_we: got %b want 0", bus.rf_we); end
        n_checks++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL stall_retire: got %b want 0", bus.retire); end
        tick(); tick();
        #1;
        n_checks++; if (bus.ready_e !== 1'b0) begin n_fail++; $display("FAIL stall_held_ready: got %b want 0", bus.ready_e); end
        bus.rf_ready = 1'b1;
        #1;
        n_checks++; if (bus.ready_e !== 1'b0) begin n_fail++; $display("FAIL stall_ready_not_comb: got %b want 0", bus.ready_e); end
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'hA1) begin n_fail++; $display("FAIL stall_write0: got we=%b a=%0d d=%h want we=1 a=11 d=a1", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
        #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'hB2) begin n_fail++; $display("FAIL stall_write1: got we=%b a=%0d d=%h want we=1 a=12 d=b2", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_checks++; if (bus.ready_e !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after_pop: got %b want 1", bus.ready_e); end
        tick();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd13 || bus.rf_wdata !== 32'hC3) begin n_fail++; $display("FAIL stall_write2: got we=%b a=%0d d=%h want we=1 a=13 d=c3", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
        #1;
        n_checks++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got retire=%b want 0", bus.retire); end
    endtask

    task automatic test_rd0_sel6();
        bus.rf_ready = 1'b1;
        drive(1'b1, 3'd3, 5'd0, 1'b1, 32'h77);
        #1; tick();
        drive(1'b1, 3'd6, 5'd4, 1'b1, 32'h55);
        #1;
        n_checks++; if (bus.retire !== 1'b1) begin n_fail++; $display("FAIL rd0_retire: got %b want 1", bus.retire); end
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_rf_we: got %b want 0", bus.rf_we); end
        tick();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4) begin n_fail++; $display("FAIL sel6_write: got we=%b a=%0d want we=1 a=4", bus.rf_we, bus.rf_waddr); end
        n_checks++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL sel6_rf_wdata: got %h want 0", bus.rf_wdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.rf_ready = 1'b0;
        drive(1'b1, 3'd0, 5'd5, 1'b1, 32'h99);
        #1; tick();
        drive(1'b1, 3'd1, 5'd6, 1'b1, 32'h98);
        #1; tick();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_checks++; if (bus.ready_e !== 1'b0) begin n_fail++; $display("FAIL midrst_two: got ready_e=%b want 0", bus.ready_e); end
        bus.rf_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        mq.delete();
        #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_rf_we: got %b want 0", bus.rf_we); end
        n_checks++; if (bus.ready_e !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_e: got %b want 1", bus.ready_e); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.rf_we !== 1'b0 || bus.retire !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write[%0d]: got we=%b retire=%b want 0 0", i, bus.rf_we, bus.retire); end
            tick();
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        bus.rf_ready = 1'b0;
        drive(1'b1, 3'd2, 5'd3, 1'b1, 32'hAA);
        #1; tick();
        drive(1'b1, 3'd4, 5'd9, 1'b1, 32'h1);
        #1;
        n_checks++; if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 5'd3 || bus.fwd_data !== 32'hAA) begin n_fail++; $display("FAIL byp_head: got v=%b a=%0d d=%h want 1 3 aa", bus.fwd_valid, bus.fwd_addr, bus.fwd_data); end
        tick();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_checks++; if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 5'd9 || bus.fwd_data !== 32'h1) begin n_fail++; $display("FAIL byp_tail: got v=%b a=%0d d=%h want 1 9 1", bus.fwd_valid, bus.fwd_addr, bus.fwd_data); end
        bus.rf_ready = 1'b1;
        #1; tick();
        bus.rf_ready = 1'b0;
        #1;
        n_checks++; if (bus.fwd_addr !== 5'd9 || bus.fwd_data !== 32'h1 || bus.rf_waddr !== 5'd9) begin n_fail++; $display("FAIL byp_after_pop: got fa=%0d fd=%h wa=%0d want 9 1 9", bus.fwd_addr, bus.fwd_data, bus.rf_waddr); end
        bus.rf_ready = 1'b1;
        #1; tick();
        #1;
        n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL byp_empty: got %b want 0", bus.fwd_valid); end
    endtask
`endif

    task automatic test_random();
        bit pend = 0;
        bit acc;
        for (int c = 0; c < 500; c++) begin
            if (!pend) begin
                if ($urandom_range(3) != 0) begin
                    pend = 1;
                    drive(1'b1, 3'($urandom_range(7)),
                          ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31)),
                          1'($urandom_range(4) != 0), $urandom);
                end else begin
                    drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
                end
            end
            bus.rf_ready = ($urandom_range(9) < 6);
            #1;
            n_checks++; if (bus.ready_e !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready_e[%0d]: got %b want %b", c, bus.ready_e, mq.size() < 2); end
            n_checks++; if (bus.retire !== ((mq.size() > 0) && bus.rf_ready)) begin n_fail++; $display("FAIL rnd_retire[%0d]: got %b", c, bus.retire); end
            if (mq.size() > 0) begin
                n_checks++; if (bus.rf_we !== (mq[0].wb_en && bus.rf_ready)) begin n_fail++; $display("FAIL rnd_rf_we[%0d]: got %b want %b", c, bus.rf_we, mq[0].wb_en && bus.rf_ready); end
                n_checks++; if (bus.rf_waddr !== mq[0].rd || bus.rf_wdata !== mq[0].data) begin n_fail++; $display("FAIL rnd_head[%0d]: got a=%0d d=%h want a=%0d d=%h", c, bus.rf_waddr, bus.rf_wdata, mq[0].rd, mq[0].data); end
            end else begin
                n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rnd_rf_we_empty[%0d]: got %b want 0", c, bus.rf_we); end
            end
`ifdef WB_BYPASS_EN
            begin
                bit          fv = 0;
                logic [4:0]  fa = '0;
                logic [31:0] fd = '0;
                for (int k = mq.size() - 1; k >= 0; k--) begin
                    if (!fv && mq[k].wb_en) begin fv = 1; fa = mq[k].rd; fd = mq[k].data; end
                end
                n_checks++; if (bus.fwd_valid !== fv) begin n_fail++; $display("FAIL rnd_fwd_valid[%0d]: got %b want %b", c, bus.fwd_valid, fv); end
                if (fv) begin
                    n_checks++; if (bus.fwd_addr !== fa || bus.fwd_data !== fd) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got a=%0d d=%h want a=%0d d=%h", c, bus.fwd_addr, bus.fwd_data, fa, fd); end
                end
            end
`endif
            acc = bus.valid_e && (mq.size() < 2);
            tick();
            if (acc) pend = 0;
        end
        drive(1'b0, 3'd0, 5'd0, 1'b0, 32'd0);
        bus.rf_ready = 1'b1;
        repeat (3) tick();
        #1;
        n_checks++; if (bus.retire !== 1'b0 || bus.ready_e !== 1'b1) begin n_fail++; $display("FAIL rnd_drain: got retire=%b ready_e=%b want 0 1", bus.retire, bus.ready_e); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_stall_fill();
        test_rd0_sel6();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
